// File: rtl/biriq_crypto_pkg.sv
// Shared types and GF(2^8) helpers for the scalar-crypto execution unit.
// Latency: none; the package holds only constants and pure functions.
// Backpressure: not applicable.
package biriq_crypto_pkg;

    typedef enum logic [2:0] {
        OP_ESI   = 3'd0,
        OP_ESMI  = 3'd1,
        OP_DSI   = 3'd2,
        OP_DSMI  = 3'd3,
        OP_SM4ED = 3'd4,
        OP_SM4KS = 3'd5
    } crypto_op_t;

    // AES field polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [8:0] AES_POLY = 9'h11B;

    // Multiply by x modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? AES_POLY[7:0] : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        gfmul = acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gfinv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gfmul(p, p);
            r = gfmul(r, p);
        end
        gfinv = r;
    endfunction

    // Rotate a word left by whole bytes
    function automatic logic [31:0] rotl32(input logic [31:0] w, input logic [1:0] nbytes);
        case (nbytes)
            2'd0:    rotl32 = w;
            2'd1:    rotl32 = {w[23:0], w[31:24]};
            2'd2:    rotl32 = {w[15:0], w[31:16]};
            default: rotl32 = {w[7:0],  w[31:8]};
        endcase
    endfunction

    // Decrypt ops use the inverse S-box
    function automatic logic op_is_inv(input crypto_op_t op);
        op_is_inv = (op == OP_DSI) || (op == OP_DSMI);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward/inverse S-box built from one shared field inverter plus affine maps.
// Latency: combinational.
// Backpressure: none; pure datapath.
module aes_sbox
    import biriq_crypto_pkg::*;
(
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        rotl8 = (v << n) | (v >> (8 - n));
    endfunction

    logic [7:0] inv_in;
    logic [7:0] inv_out;

    // Inverse path undoes the affine map before inverting; forward path applies it after
    always_comb begin
        inv_in  = inv ? (rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05) : din;
        inv_out = gfinv(inv_in);
        dout    = inv ? inv_out
                      : (inv_out ^ rotl8(inv_out, 1) ^ rotl8(inv_out, 2)
                                 ^ rotl8(inv_out, 3) ^ rotl8(inv_out, 4) ^ 8'h63);
    end

endmodule

// File: rtl/byteselect.sv
// Picks one byte of a 32-bit word by index.
// Latency: combinational.
// Backpressure: none; pure datapath.
module byteselect (
    input  logic [31:0] word,
    input  logic [1:0]  sel,
    output logic [7:0]  bsel
);

    // Byte multiplexer, byte 0 is the least significant
    always_comb begin
        bsel = word[7:0];
        case (sel)
            2'd0:    bsel = word[7:0];
            2'd1:    bsel = word[15:8];
            2'd2:    bsel = word[23:16];
            default: bsel = word[31:24];
        endcase
    end

endmodule

// File: rtl/aes32_unit.sv
// Two-stage aes32*/sm4* execution unit: byte pick + S-box, then mix/rotate/xor. Optional SM4 via BIRIQ_SM4_EN.
// Latency: 2 cycles from op presented to result_valid_o; one op per cycle sustained.
// Backpressure: stalled result holds stable, stage 1 holds behind it, ins_ready_o drops only when both are full.
module aes32_unit
    import biriq_crypto_pkg::*;
#(
    parameter int ROB_W = 6
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_i,
    input  logic             flush_i,
    input  logic             ins_valid_i,
    output logic             ins_ready_o,
    input  logic [2:0]       opcode_i,
    input  logic [31:0]      rs1_i,
    input  logic [31:0]      rs2_i,
    input  logic [1:0]       bs_i,
    input  logic [ROB_W-1:0] rob_id_i,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [31:0]      result_o,
    output logic [ROB_W-1:0] result_rob_id_o
);

`ifdef BIRIQ_SM4_EN
    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };
`endif

    crypto_op_t       in_op;
    logic [7:0]       pick;
    logic [7:0]       sbox_out;
    logic             adv2;
    logic             accept;

    logic             s1_valid;
    crypto_op_t       s1_op;
    logic [1:0]       s1_bs;
    logic [31:0]      s1_rs1;
    logic [ROB_W-1:0] s1_tag;
    logic [7:0]       s1_sbox;
`ifdef BIRIQ_SM4_EN
    logic [7:0]       s1_sm4;
    logic [31:0]      sm4_x;
`endif

    logic [31:0]      s2_word;
    logic [31:0]      s2_result;

    assign in_op = crypto_op_t'(opcode_i);

    byteselect u_byteselect (
        .word (rs2_i),
        .sel  (bs_i),
        .bsel (pick)
    );

    aes_sbox u_aes_sbox (
        .din  (pick),
        .inv  (op_is_inv(in_op)),
        .dout (sbox_out)
    );

    // Stage 2 drains whenever the result slot is empty or being consumed; stage 1 refills behind it
    always_comb begin
        adv2        = !result_valid_o || result_ready_i;
        ins_ready_o = !s1_valid || adv2;
        accept      = ins_valid_i && ins_ready_o;
    end

    // Stage 1 operand capture; payload needs no reset because s1_valid qualifies it
    always_ff @(posedge cpu_clock_i) begin
        if (accept) begin
            s1_op   <= in_op;
            s1_bs   <= bs_i;
            s1_rs1  <= rs1_i;
            s1_tag  <= rob_id_i;
            s1_sbox <= sbox_out;
`ifdef BIRIQ_SM4_EN
            s1_sm4  <= SM4_SBOX[pick];
`endif
        end
    end

`ifdef BIRIQ_SM4_EN
    assign sm4_x = {24'h0, s1_sm4};
`endif

    // Stage 2 word expansion from the substituted byte, then rotate into place and fold in rs1
    always_comb begin
        s2_word = 32'h0;
        case (s1_op)
            OP_ESI, OP_DSI: s2_word = {24'h0, s1_sbox};
            OP_ESMI:        s2_word = {gfmul(s1_sbox, 8'h03), s1_sbox, s1_sbox, gfmul(s1_sbox, 8'h02)};
            OP_DSMI:        s2_word = {gfmul(s1_sbox, 8'h0B), gfmul(s1_sbox, 8'h0D),
                                       gfmul(s1_sbox, 8'h09), gfmul(s1_sbox, 8'h0E)};
`ifdef BIRIQ_SM4_EN
            OP_SM4ED:       s2_word = sm4_x ^ (sm4_x << 8) ^ (sm4_x << 2) ^ (sm4_x << 18)
                                    ^ ((sm4_x & 32'h3F) << 26) ^ ((sm4_x & 32'hC0) << 10);
            OP_SM4KS:       s2_word = sm4_x ^ ((sm4_x & 32'h07) << 29) ^ ((sm4_x & 32'hFE) << 7)
                                    ^ ((sm4_x & 32'h01) << 23) ^ ((sm4_x & 32'hF8) << 13);
`endif
            default:        s2_word = 32'h0;
        endcase
        s2_result = rotl32(s2_word, s1_bs) ^ s1_rs1;
    end

    // Pipeline occupancy and result register; flush kills both stages and drops any op offered alongside it
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            s1_valid        <= 1'b0;
            result_valid_o  <= 1'b0;
            result_o        <= 32'h0;
            result_rob_id_o <= '0;
        end else if (flush_i) begin
            s1_valid       <= 1'b0;
            result_valid_o <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end
            if (adv2) begin
                result_valid_o <= s1_valid;
                if (s1_valid) begin
                    result_o        <= s2_result;
                    result_rob_id_o <= s1_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes32_unit.sv
// Randomized scoreboard bench for aes32_unit against a table-driven AES reference.
// Latency: checks the 2-cycle issue-to-result timing on the first op.
// Backpressure: exercises random and held result_ready_i, flush and mid-flight reset.
module tb_aes32_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ins_valid;
    logic        ins_ready;
    logic [2:0]  opcode;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  bs;
    logic [5:0]  rob_id;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic [5:0]  result_rob_id;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   tag_ctr = 0;
    int   rdy_mode = 1;
    int   sb[256];
    int   isb[256];

    always #5 clk = ~clk;

    aes32_unit #(.ROB_W(6)) dut (
        .cpu_clock_i     (clk),
        .cpu_reset_i     (rst),
        .flush_i         (flush),
        .ins_valid_i     (ins_valid),
        .ins_ready_o     (ins_ready),
        .opcode_i        (opcode),
        .rs1_i           (rs1),
        .rs2_i           (rs2),
        .bs_i            (bs),
        .rob_id_i        (rob_id),
        .result_valid_o  (result_valid),
        .result_ready_i  (result_ready),
        .result_o        (result),
        .result_rob_id_o (result_rob_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Carry-less product then long division by 0x11B
    function automatic int gmul_ref(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ ('h11B << (i - 8));
        return p & 255;
    endfunction

    function automatic int affine_ref(input int b);
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            int bit_v;
            bit_v = ((b >> i) ^ (b >> ((i + 4) % 8)) ^ (b >> ((i + 5) % 8))
                    ^ (b >> ((i + 6) % 8)) ^ (b >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
            s = s | (bit_v << i);
        end
        return s;
    endfunction

    function automatic logic [31:0] rotl_ref(input logic [31:0] w, input int n);
        if (n == 0) return w;
        return (w << (8 * n)) | (w >> (32 - 8 * n));
    endfunction

    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b, input int sel);
        int          x;
        int          s;
        logic [31:0] w;
        x = int'((b >> (8 * sel)) & 32'hFF);
        w = 32'h0;
        case (op)
            0: w = 32'(sb[x]);
            1: begin s = sb[x];  w = 32'((gmul_ref(s, 3) << 24) | (s << 16) | (s << 8) | gmul_ref(s, 2)); end
            2: w = 32'(isb[x]);
            3: begin s = isb[x]; w = 32'((gmul_ref(s, 11) << 24) | (gmul_ref(s, 13) << 16)
                                         | (gmul_ref(s, 9) << 8) | gmul_ref(s, 14)); end
            default: w = 32'h0;
        endcase
        return rotl_ref(w, sel) ^ a;
    endfunction

    task automatic send(input int op, input logic [31:0] a, input logic [31:0] b, input int sel,
                        input logic [31:0] expv);
        int   tries = 0;
        exp_t e;
        opcode    = 3'(op);
        rs1       = a;
        rs2       = b;
        bs        = 2'(sel);
        rob_id    = 6'(tag_ctr);
        ins_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (ins_ready) break;
            tries++;
            if (tries > 50) begin
                check("issue_timeout", 32'(tries), 32'd0);
                break;
            end
        end
        if (ins_ready) begin
            e.res = expv;
            e.tag = 6'(tag_ctr);
            exp_q.push_back(e);
        end
        tag_ctr++;
        @(posedge clk);
        #1;
        ins_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        rdy_mode = 1;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Result-ready driver
    initial begin
        result_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) result_ready = 1'($urandom_range(0, 1));
            else               result_ready = (rdy_mode == 1);
        end
    end

    // Monitor: scoreboard pop, hold stability and occupancy-based ready check
    initial begin
        int          in_flight = 0;
        logic        hold = 1'b0;
        logic [31:0] hres = 32'h0;
        logic [5:0]  htag = 6'h0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                in_flight = 0;
                hold = 1'b0;
            end else begin
                check("ins_ready", 32'(ins_ready), 32'((in_flight < 2) || result_ready));
                if (hold) begin
                    check("hold_valid", 32'(result_valid), 32'd1);
                    check("hold_result", result, hres);
                    check("hold_tag", 32'(result_rob_id), 32'(htag));
                end
                if (flush) begin
                    exp_q.delete();
                    in_flight = 0;
                    hold = 1'b0;
                end else begin
                    if (result_valid && result_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_result", result, 32'hx);
                        end else begin
                            e = exp_q.pop_front();
                            check("result", result, e.res);
                            check("tag", 32'(result_rob_id), 32'(e.tag));
                        end
                    end
                    in_flight = in_flight + int'(ins_valid && ins_ready) - int'(result_valid && result_ready);
                    hold = result_valid && !result_ready;
                    hres = result;
                    htag = result_rob_id;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int op;
        logic [31:0] a;
        logic [31:0] b;
        int sel;

        for (int x = 0; x < 256; x++) begin
            int inv_x = 0;
            for (int y = 1; y < 256; y++) if (gmul_ref(x, y) == 1) inv_x = y;
            sb[x] = affine_ref(inv_x);
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = x;

        rst = 1'b1; flush = 1'b0; ins_valid = 1'b0; opcode = 3'd0;
        rs1 = 32'h0; rs2 = 32'h0; bs = 2'd0; rob_id = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_tag", 32'(result_rob_id), 32'h0);
        check("rst_ready", 32'(ins_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency of a lone op
        send(0, 32'h0, 32'h00000053, 0, 32'h000000ED);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!result_valid && lat < 10);
        check("latency", 32'(lat), 32'd2);
        @(posedge clk);
        #1;

        // Known-answer vectors
        send(0, 32'h0,        32'h00005300, 1, 32'h0000ED00);
        send(1, 32'h0,        32'h00000001, 0, 32'h847C7CF8);
        send(1, 32'hFFFFFFFF, 32'h00000001, 0, 32'h7B838307);
        send(2, 32'h0,        32'h000000ED, 0, 32'h00000053);
        send(3, 32'h0,        32'h00000000, 0, model(3, 32'h0, 32'h0, 0));
        send(7, 32'h12345678, 32'hCAFEF00D, 2, 32'h12345678);
`ifdef BIRIQ_SM4_EN
        send(5, 32'h0, 32'h0, 0, 32'hC01A6BD6);
`else
        send(5, 32'h0, 32'h0, 0, 32'h00000000);
        send(4, 32'hA5A5A5A5, 32'h11223344, 3, 32'hA5A5A5A5);
`endif
        drain();

        // Four ops back to back against a stalled writeback
        rdy_mode = 2;
        @(posedge clk);
        #1;
        fork
            begin
                repeat (5) @(posedge clk);
                rdy_mode = 1;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    b = $urandom;
                    a = $urandom;
                    send(i, a, b, i, model(i, a, b, i));
                end
            end
        join
        drain();

        // Flush with both stages full and a third op offered
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(0, 32'h0, 32'h00000053, 0, 32'h000000ED);
        send(1, 32'h0, 32'h00000001, 0, 32'h847C7CF8);
        opcode = 3'd2; rs1 = 32'h0; rs2 = 32'hED; bs = 2'd0; rob_id = 6'h3F;
        ins_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        ins_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(result_valid), 32'd0);
        check("flush_ready", 32'(ins_ready), 32'd1);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send(2, 32'h0, 32'h000000ED, 0, 32'h00000053);
        drain();

        // Reset while the pipeline holds ops
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(0, 32'h0, 32'h00000053, 0, 32'h000000ED);
        send(0, 32'h0, 32'h00000053, 1, 32'h0000ED00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(result_valid), 32'd0);
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_tag", 32'(result_rob_id), 32'h0);
        check("mid_rst_ready", 32'(ins_ready), 32'd1);
        @(posedge clk);
        #1;
        rdy_mode = 1;

        // Random traffic with random writeback stalls
        rdy_mode = 0;
        for (int n = 0; n < 400; n++) begin
`ifdef BIRIQ_SM4_EN
            op = $urandom_range(0, 5);
            if (op >= 4) op = op + 2;
`else
            op = $urandom_range(0, 7);
`endif
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 3);
            send(op, a, b, sel, model(op, a, b, sel));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
